// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment scan driver: double-buffered display word,
// frame-aligned commit, blanking dead-time on digit change, optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  digit_sel,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic        lz_en,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_sync,
  output logic        pending
);

  logic [31:0]      active_word_reg;
  logic [7:0]       active_dp_reg;
  logic [31:0]      pend_word_reg;
  logic [7:0]       pend_dp_reg;
  logic             pend_full_reg;
  logic [2:0]       sel_reg;
  logic [CNT_W-1:0] blank_cnt_reg;

  logic       change;
  logic       frame_start;
  logic       load_fire;
  logic [3:0] nib;
  logic [6:0] seg_enc;
  logic [7:0] upper_zero;
  logic       suppress;
  logic [7:0] an_drive;
  logic [6:0] seg_drive;
  logic       dp_drive;

  // upper_zero[k]: nibbles k..7 of the active word are all zero
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (active_word_reg[31:4*gi] == '0);
    end
  endgenerate

  assign load_ready = !pend_full_reg;
  assign pending    = pend_full_reg;

  always_comb begin
    change      = (digit_sel != sel_reg);
    frame_start = change && (digit_sel == 3'd0);
    load_fire   = load_valid && load_ready;
    nib         = active_word_reg[{sel_reg, 2'b00} +: 4];
    seg_enc     = 7'h7F;
    case (nib)
      4'h0: seg_enc = 7'h40;
      4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;
      4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;
      4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;
      4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;
      4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;
      4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;
      4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;
      4'hF: seg_enc = 7'h0E;
      default: seg_enc = 7'h7F;
    endcase
    // digit 0 is never blanked so an all-zero word still reads "0"
    suppress  = lz_en && (sel_reg != 3'd0) && upper_zero[sel_reg];
    an_drive  = ~(8'b1 << sel_reg);
    seg_drive = suppress ? 7'h7F : seg_enc;
    dp_drive  = ~active_dp_reg[sel_reg];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_word_reg <= '0;
      active_dp_reg   <= '0;
      pend_word_reg   <= '0;
      pend_dp_reg     <= '0;
      pend_full_reg   <= 1'b0;
      sel_reg         <= 3'd0;
      blank_cnt_reg   <= '0;
      an_n            <= 8'hFF;
      seg_n           <= 7'h7F;
      dp_n            <= 1'b1;
      frame_sync      <= 1'b0;
    end else begin
      frame_sync <= frame_start;

      if (change) begin
        sel_reg       <= digit_sel;
        blank_cnt_reg <= CNT_W'(BLANK_CYCLES);
        an_n          <= 8'hFF;
        seg_n         <= 7'h7F;
        dp_n          <= 1'b1;
      end else if (blank_cnt_reg != '0) begin
        blank_cnt_reg <= blank_cnt_reg - 1'b1;
        an_n          <= 8'hFF;
        seg_n         <= 7'h7F;
        dp_n          <= 1'b1;
      end else begin
        an_n  <= an_drive;
        seg_n <= seg_drive;
        dp_n  <= dp_drive;
      end

      // commit and accept never collide: accept needs pend_full=0, commit needs pend_full=1
      if (frame_start && pend_full_reg) begin
        active_word_reg <= pend_word_reg;
        active_dp_reg   <= pend_dp_reg;
        pend_full_reg   <= 1'b0;
      end else if (load_fire) begin
        pend_word_reg <= load_data;
        pend_dp_reg   <= load_dp;
        pend_full_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver (BLANK_CYCLES=2).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  digit_sel;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic        lz_en;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_sync;
  logic        pending;

  int checks   = 0;
  int failures = 0;

  seg7_scan_driver #(.BLANK_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .digit_sel(digit_sel),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .lz_en(lz_en),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .frame_sync(frame_sync), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // move to digit k and wait out the full blanking window
  task automatic step(input logic [2:0] k);
    digit_sel = k;
    repeat (4) tick();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    int n;
    n = 0;
    load_data  = d;
    load_dp    = p;
    load_valid = 1'b1;
    while (!load_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!load_ready) begin
      failures++;
      $display("FAIL load_timeout: load_ready=%b required 1 within 20 cycles", load_ready);
    end
    tick();
    load_valid = 1'b0;
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL load_accept: pending=%b required 1", pending); end
  endtask

  task automatic test_reset();
    rst = 1'b0; digit_sel = 3'd0; load_valid = 1'b0; load_data = '0; load_dp = '0; lz_en = 1'b0;
    repeat (2) tick();
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin failures++;
      $display("FAIL reset_outputs: an=%h seg=%h dp=%b required FF/7F/1", an_n, seg_n, dp_n); end
    checks++;
    if ({load_ready, pending, frame_sync} !== 3'b100) begin failures++;
      $display("FAIL reset_flags: ready=%b pend=%b fs=%b required 1/0/0", load_ready, pending, frame_sync); end
    rst = 1'b1;
    tick();
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFE, 7'h40, 1'b1}) begin failures++;
      $display("FAIL reset_first_digit: an=%h seg=%h dp=%b required FE/40/1", an_n, seg_n, dp_n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (frame_sync !== 1'b0) begin failures++; $display("FAIL reset_no_fs: fs=%b required 0 at cycle %0d", frame_sync, i); end
    end
  endtask

  task automatic test_commit();
    do_load(32'h89AB_CDEF, 8'h01);
    step(3'd7);
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL commit_hold: pending=%b required 1 before frame", pending); end
    digit_sel = 3'd0;
    tick();
    checks++;
    if ({frame_sync, an_n, pending} !== {1'b1, 8'hFF, 1'b0}) begin failures++;
      $display("FAIL commit_e0: fs=%b an=%h pend=%b required 1/FF/0", frame_sync, an_n, pending); end
    tick();
    checks++;
    if ({frame_sync, an_n} !== {1'b0, 8'hFF}) begin failures++;
      $display("FAIL commit_e1: fs=%b an=%h required 0/FF", frame_sync, an_n); end
    tick();
    checks++;
    if ({frame_sync, an_n} !== {1'b0, 8'hFF}) begin failures++;
      $display("FAIL commit_e2: fs=%b an=%h required 0/FF", frame_sync, an_n); end
    tick();
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFE, 7'h0E, 1'b0}) begin failures++;
      $display("FAIL commit_show: an=%h seg=%h dp=%b required FE/0E/0", an_n, seg_n, dp_n); end
  endtask

  task automatic test_blank_latency();
    do_load(32'h1234_5678, 8'h00);
    step(3'd1);
    step(3'd0);
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFE, 7'h00, 1'b1}) begin failures++;
      $display("FAIL latency_d0: an=%h seg=%h dp=%b required FE/00/1", an_n, seg_n, dp_n); end
    digit_sel = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin failures++;
        $display("FAIL latency_blank%0d: an=%h seg=%h dp=%b required FF/7F/1", i, an_n, seg_n, dp_n); end
    end
    tick();
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFD, 7'h78, 1'b1}) begin failures++;
      $display("FAIL latency_show: an=%h seg=%h dp=%b required FD/78/1", an_n, seg_n, dp_n); end
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({an_n, seg_n, frame_sync} !== {8'hFD, 7'h78, 1'b0}) begin failures++;
        $display("FAIL stuck_%0d: an=%h seg=%h fs=%b required FD/78/0", i, an_n, seg_n, frame_sync); end
    end
  endtask

  task automatic test_back_to_back();
    do_load(32'h0000_000A, 8'h00);
    load_data = 32'h0000_000B; load_dp = 8'h00; load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({load_ready, pending} !== 2'b01) begin failures++;
        $display("FAIL b2b_blocked%0d: ready=%b pend=%b required 0/1", i, load_ready, pending); end
    end
    digit_sel = 3'd0;
    tick();
    checks++;
    if ({frame_sync, pending, load_ready} !== 3'b101) begin failures++;
      $display("FAIL b2b_commit: fs=%b pend=%b ready=%b required 1/0/1", frame_sync, pending, load_ready); end
    tick();
    load_valid = 1'b0;
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL b2b_accept_b: pending=%b required 1", pending); end
    repeat (2) tick();
    checks++;
    if ({an_n, seg_n} !== {8'hFE, 7'h08}) begin failures++;
      $display("FAIL b2b_shows_a: an=%h seg=%h required FE/08", an_n, seg_n); end
    step(3'd3);
    step(3'd0);
    checks++;
    if ({an_n, seg_n, pending} !== {8'hFE, 7'h03, 1'b0}) begin failures++;
      $display("FAIL b2b_shows_b: an=%h seg=%h pend=%b required FE/03/0", an_n, seg_n, pending); end
  endtask

  task automatic test_lz();
    logic [6:0] exp_seg [8];
    exp_seg = '{7'h40, 7'h12, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    lz_en = 1'b1;
    do_load(32'h0000_0450, 8'h20);
    step(3'd1);
    step(3'd0);
    for (int k = 7; k >= 0; k--) begin
      step(3'(k));
      checks++;
      if ({an_n, seg_n, dp_n} !== {~(8'b1 << k), exp_seg[k], (k == 5) ? 1'b0 : 1'b1}) begin failures++;
        $display("FAIL lz_digit%0d: an=%h seg=%h dp=%b required %h/%h/%b", k, an_n, seg_n, dp_n,
                 ~(8'b1 << k), exp_seg[k], (k == 5) ? 1'b0 : 1'b1); end
    end
    do_load(32'h0000_0000, 8'h00);
    step(3'd2);
    step(3'd0);
    checks++;
    if ({an_n, seg_n} !== {8'hFE, 7'h40}) begin failures++;
      $display("FAIL lz_zero_d0: an=%h seg=%h required FE/40", an_n, seg_n); end
    step(3'd3);
    checks++;
    if ({an_n, seg_n} !== {8'hF7, 7'h7F}) begin failures++;
      $display("FAIL lz_zero_d3: an=%h seg=%h required F7/7F", an_n, seg_n); end
    lz_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_load(32'hFFFF_FFFF, 8'hFF);
    digit_sel = 3'd6;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin failures++;
      $display("FAIL midrst_outputs: an=%h seg=%h dp=%b required FF/7F/1", an_n, seg_n, dp_n); end
    checks++;
    if ({pending, load_ready} !== 2'b01) begin failures++;
      $display("FAIL midrst_flags: pend=%b ready=%b required 0/1", pending, load_ready); end
    digit_sel = 3'd0;
    rst = 1'b1;
    tick();
    checks++;
    if ({an_n, seg_n, dp_n} !== {8'hFE, 7'h40, 1'b1}) begin failures++;
      $display("FAIL midrst_after: an=%h seg=%h dp=%b required FE/40/1", an_n, seg_n, dp_n); end
  endtask

  initial begin
    test_reset();
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
    test_commit();
    $display("test_commit done checks=%0d failures=%0d", checks, failures);
    test_blank_latency();
    $display("test_blank_latency done checks=%0d failures=%0d", checks, failures);
    test_stuck();
    $display("test_stuck done checks=%0d failures=%0d", checks, failures);
    test_back_to_back();
    $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    test_lz();
    $display("test_lz done checks=%0d failures=%0d", checks, failures);
    test_reset_mid();
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
